mem_bus_decoder: RTL and testbench

Address decoder and response mux for the PicoRV32-style memory bus (valid/ready/addr/wdata/wstrb/rdata). Sits between a single bus master (CPU or test sequencer) and its slaves: forwards BRAM-window accesses to `bram_controller` and serves a small GPIO register bank (LEDs, buttons, error counter) locally. Unmapped, misaligned or timed-out accesses complete with a fixed error pattern so the master never hangs.

---
 rtl/mem_bus_pkg.sv | 28 ++
 rtl/btn_sync.sv | 23 ++
 rtl/mem_bus_decoder.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_decoder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared state encoding, error pattern and GPIO register offsets for mem_bus_decoder.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BRAM_WAIT = 2'd1,
      RESP      = 2'd2
   } state_t;

   localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
   localparam logic [3:0]  GPIO_LED    = 4'h0;
   localparam logic [3:0]  GPIO_BTN    = 4'h4;
   localparam logic [3:0]  GPIO_ERRCNT = 4'h8;

   // 33-bit compare so a window ending at 2^32 does not wrap.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + {1'b0, size};
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw push-button inputs.
module btn_sync #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         dout <= '0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/mem_bus_decoder.sv
// Memory bus decoder: BRAM window forwarding, local GPIO bank, error completion.
// Optional BRAM wait timeout enabled by MEM_BUS_DECODER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for mem_valid; decodes and latches the request
// BRAM_WAIT | bram_valid asserted, waiting for bram_ready (or timeout)
// RESP      | one-cycle mem_ready pulse back to the master
module mem_bus_decoder
   import mem_bus_pkg::*;
#(
   parameter logic [31:0] BRAM_BASE      = 32'h0000_0000,
   parameter logic [31:0] BRAM_SIZE      = 32'h0000_1000,
   parameter logic [31:0] GPIO_BASE      = 32'h1000_0000,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        bram_valid,
   input  logic        bram_ready,
   output logic [31:0] bram_addr,
   output logic [31:0] bram_wdata,
   output logic [3:0]  bram_wstrb,
   input  logic [31:0] bram_rdata,
   output logic [7:0]  led,
   input  logic [6:0]  btn
);

   localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES);

   state_t      state;
   state_t      state_nxt;
   logic [6:0]  btn_s;
   logic [7:0]  errcnt;
   logic [31:0] gpio_rd;

   logic        misaligned;
   logic        bram_hit;
   logic        gpio_hit;
   logic        start;
   logic        err_acc;
   logic        go_bram;
   logic        gpio_acc;
   logic        gpio_wr;
   logic        timeout;
   logic        err_evt;

   btn_sync #(.W(7)) u_btn_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (btn),
      .dout    (btn_s)
   );

   always_comb begin
      misaligned = (mem_addr[1:0] != 2'b00);
      bram_hit   = in_window(mem_addr, BRAM_BASE, BRAM_SIZE);
      gpio_hit   = (mem_addr[31:4] == GPIO_BASE[31:4]);
      start      = (state == IDLE) && mem_valid;
      go_bram    = start && !misaligned && bram_hit;
      gpio_acc   = start && !misaligned && !bram_hit && gpio_hit;
      err_acc    = start && (misaligned || (!bram_hit && !gpio_hit));
      gpio_wr    = gpio_acc && (mem_wstrb != 4'b0000);
      err_evt    = err_acc || timeout;
   end

   always_comb begin
      gpio_rd = 32'h0;
      case (mem_addr[3:0])
         GPIO_LED:    gpio_rd = {24'h0, led};
         GPIO_BTN:    gpio_rd = {25'h0, btn_s};
         GPIO_ERRCNT: gpio_rd = {24'h0, errcnt};
         default:     gpio_rd = 32'h0;
      endcase
   end

`ifdef MEM_BUS_DECODER_TIMEOUT_EN
   // Down-counter loaded on entry to BRAM_WAIT; reaching zero equals
   // TIMEOUT_CYCLES elapsed wait cycles counted up from zero.
   logic [15:0] tmr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr <= 16'h0;
      end else if (go_bram) begin
         tmr <= TMR_LOAD;
      end else if ((state == BRAM_WAIT) && (tmr != 16'h0)) begin
         tmr <= tmr - 16'd1;
      end
   end

   assign timeout = (state == BRAM_WAIT) && !bram_ready && (tmr == 16'h0);
`else
   logic unused_cfg;
   assign unused_cfg = ^TMR_LOAD;
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      mem_ready  = 1'b0;
      bram_valid = 1'b0;
      case (state)
         IDLE: begin
            if (mem_valid) begin
               state_nxt = go_bram ? BRAM_WAIT : RESP;
            end
         end
         BRAM_WAIT: begin
            bram_valid = 1'b1;
            if (bram_ready || timeout) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            mem_ready = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bram_addr  <= 32'h0;
         bram_wdata <= 32'h0;
         bram_wstrb <= 4'h0;
         mem_rdata  <= 32'h0;
         led        <= 8'h00;
         errcnt     <= 8'h00;
      end else begin
         if (go_bram) begin
            bram_addr  <= mem_addr - BRAM_BASE;
            bram_wdata <= mem_wdata;
            bram_wstrb <= mem_wstrb;
         end

         if (err_acc || timeout) begin
            mem_rdata <= ERR_DATA;
         end else if (gpio_acc) begin
            mem_rdata <= gpio_rd;
         end else if ((state == BRAM_WAIT) && bram_ready) begin
            mem_rdata <= bram_rdata;
         end

         if (gpio_wr && (mem_addr[3:0] == GPIO_LED) && mem_wstrb[0]) begin
            led <= mem_wdata[7:0];
         end

         // A clear beats a simultaneous error.
         if (gpio_wr && (mem_addr[3:0] == GPIO_ERRCNT)) begin
            errcnt <= 8'h00;
         end else if (err_evt && (errcnt != 8'hFF)) begin
            errcnt <= errcnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Scoreboard bench for mem_bus_decoder: random and directed bus traffic checked against a reference model.
module tb_mem_bus_decoder;

   localparam logic [31:0] BRAM_BASE = 32'h0000_0000;
   localparam logic [31:0] BRAM_SIZE = 32'h0000_1000;
   localparam logic [31:0] GPIO_BASE = 32'h1000_0000;
   localparam int          TO        = 8;
   localparam logic [31:0] DEAD      = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        bram_valid;
   logic        bram_ready;
   logic [31:0] bram_addr;
   logic [31:0] bram_wdata;
   logic [3:0]  bram_wstrb;
   logic [31:0] bram_rdata;
   logic [7:0]  led;
   logic [6:0]  btn;

   mem_bus_decoder #(
      .BRAM_BASE      (BRAM_BASE),
      .BRAM_SIZE      (BRAM_SIZE),
      .GPIO_BASE      (GPIO_BASE),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .bram_valid (bram_valid),
      .bram_ready (bram_ready),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .bram_wstrb (bram_wstrb),
      .bram_rdata (bram_rdata),
      .led        (led),
      .btn        (btn)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // kind: 0 local (GPIO/error), 1 BRAM served, 2 BRAM timeout
   typedef struct {
      int          kind;
      bit          chk;
      logic [31:0] rdata;
      logic [7:0]  led;
      int          issue;
      string       name;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } breq_t;

   exp_t        exp_q[$];
   breq_t       breq_q[$];
   logic [31:0] ref_mem [int];
   logic [31:0] slv_mem [int];
   logic [7:0]  ref_led = 8'h00;
   int          ref_err = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          last_rdy = 0;
   bit          slv_en = 1'b1;
   int          slv_lat = -1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void err_inc();
      if (ref_err < 255) ref_err++;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      return w;
   endfunction

   // BRAM slave: checks forwarded fields, responds after slv_lat (or random) cycles.
   initial begin
      bit    busy;
      int    cnt;
      int    idx;
      breq_t r;
      logic [31:0] w;
      busy = 1'b0;
      cnt = 0;
      bram_ready = 1'b0;
      bram_rdata = 32'h0;
      forever begin
         @(negedge clk);
         bram_ready = 1'b0;
         if (!reset_n || !bram_valid || !slv_en) begin
            busy = 1'b0;
         end else begin
            if (!busy) begin
               busy = 1'b1;
               cnt = (slv_lat >= 0) ? slv_lat : int'($urandom_range(0, 3));
               if (breq_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL bram_unexpected: got request addr %h, expected none", bram_addr);
               end else begin
                  r = breq_q.pop_front();
                  chk("bram_addr", bram_addr, r.addr);
                  chk("bram_wdata", bram_wdata, r.wdata);
                  chk("bram_wstrb", {28'h0, bram_wstrb}, {28'h0, r.wstrb});
               end
            end
            if (cnt == 0) begin
               idx = int'(bram_addr >> 2);
               w = slv_mem.exists(idx) ? slv_mem[idx] : 32'h0;
               if (bram_wstrb == 4'h0) begin
                  bram_rdata = w;
               end else begin
                  slv_mem[idx] = merge(w, bram_wdata, bram_wstrb);
                  bram_rdata = $urandom;
               end
               bram_ready = 1'b1;
               busy = 1'b0;
               last_rdy = cyc;
            end else begin
               cnt--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every mem_ready pulse.
   initial begin
      exp_t e;
      bit   prev;
      int   want;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev = 1'b0;
         end else if (mem_ready) begin
            chk("ready_single_pulse", {31'h0, prev}, 32'h0);
            chk("bram_valid_low_at_resp", {31'h0, bram_valid}, 32'h0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_resp: got mem_ready with rdata %h, expected no response", mem_rdata);
            end else begin
               e = exp_q.pop_front();
               if (e.chk) chk({e.name, "_rdata"}, mem_rdata, e.rdata);
               chk({e.name, "_led"}, {24'h0, led}, {24'h0, e.led});
               if (e.kind == 0)      want = e.issue + 1;
               else if (e.kind == 1) want = last_rdy + 1;
               else                  want = e.issue + TO + 2;
               chk({e.name, "_cycle"}, 32'(cyc), 32'(want));
            end
            prev = 1'b1;
         end else begin
            prev = 1'b0;
         end
      end
   end

   task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input string nm, input bit to_exp);
      exp_t  e;
      breq_t r;
      int    idx;
      int    off;
      bit    done;
      logic [31:0] w;
      e.name = nm;
      e.kind = 0;
      e.chk = (s == 4'h0);
      e.rdata = 32'h0;
      if (a % 4 != 0) begin
         e.rdata = DEAD;
         e.chk = 1'b1;
         err_inc();
      end else if (longint'(a) >= longint'(BRAM_BASE) &&
                   longint'(a) < longint'(BRAM_BASE) + longint'(BRAM_SIZE)) begin
         if (to_exp) begin
            e.kind = 2;
            e.rdata = DEAD;
            e.chk = 1'b1;
            err_inc();
         end else begin
            e.kind = 1;
            idx = int'((a - BRAM_BASE) / 4);
            r.addr = a - BRAM_BASE;
            r.wdata = d;
            r.wstrb = s;
            breq_q.push_back(r);
            w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
            if (s == 4'h0) e.rdata = w;
            else ref_mem[idx] = merge(w, d, s);
         end
      end else if (longint'(a) >= longint'(GPIO_BASE) &&
                   longint'(a) < longint'(GPIO_BASE) + 16) begin
         off = int'(a - GPIO_BASE);
         case (off)
            0: begin
               e.rdata = {24'h0, ref_led};
               if (s[0]) ref_led = d[7:0];
            end
            4: e.rdata = {25'h0, btn};
            8: begin
               e.rdata = 32'(ref_err);
               if (s != 4'h0) ref_err = 0;
            end
            default: e.rdata = 32'h0;
         endcase
      end else begin
         e.rdata = DEAD;
         e.chk = 1'b1;
         err_inc();
      end
      e.led = ref_led;
      mem_addr = a;
      mem_wdata = d;
      mem_wstrb = s;
      mem_valid = 1'b1;
      e.issue = cyc;
      exp_q.push_back(e);
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (mem_ready) done = 1'b1;
      end
      mem_valid = 1'b0;
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_no_ready: got no mem_ready in 100 cycles, expected a response", nm);
         exp_q.delete();
         breq_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          sel;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;

      mem_valid = 1'b0;
      mem_addr = 32'h0;
      mem_wdata = 32'h0;
      mem_wstrb = 4'h0;
      btn = 7'h00;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      chk("rst_bram_valid", {31'h0, bram_valid}, 32'h0);
      chk("rst_bram_addr", bram_addr, 32'h0);
      chk("rst_bram_wdata", bram_wdata, 32'h0);
      chk("rst_bram_wstrb", {28'h0, bram_wstrb}, 32'h0);
      chk("rst_led", {24'h0, led}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      slv_mem[0] = 32'h81;
      ref_mem[0] = 32'h81;
      slv_lat = 3;
      txn(32'h0000_0000, 32'h0, 4'h0, "bram_rd0", 1'b0);
      slv_lat = -1;
      txn(GPIO_BASE, 32'hA5, 4'b0001, "led_wr", 1'b0);
      txn(GPIO_BASE, 32'h0, 4'h0, "led_rd", 1'b0);
      txn(GPIO_BASE + 8, 32'h0, 4'h0, "errcnt_rst", 1'b0);
      btn = 7'h05;
      repeat (3) @(negedge clk);
      txn(GPIO_BASE + 4, 32'h0, 4'h0, "btn_rd", 1'b0);
      txn(32'h2000_0000, 32'h0, 4'h0, "unmapped", 1'b0);
      txn(32'h0000_0002, 32'h0, 4'h0, "misaligned", 1'b0);
      txn(GPIO_BASE + 8, 32'h0, 4'h0, "errcnt_2", 1'b0);
      txn(GPIO_BASE + 8, 32'h0, 4'hF, "errcnt_clr", 1'b0);
      txn(GPIO_BASE + 8, 32'h0, 4'h0, "errcnt_0", 1'b0);

      txn(32'h0000_0FFC, 32'h1234_5678, 4'hF, "bram_last_wr", 1'b0);
      txn(32'h0000_0FFC, 32'h0, 4'h0, "bram_last_rd", 1'b0);
      txn(32'h0000_1000, 32'h0, 4'h0, "bram_end", 1'b0);
      txn(GPIO_BASE + 32'h10, 32'h0, 4'h0, "gpio_end", 1'b0);
      txn(32'hFFFF_FFFC, 32'h0, 4'h0, "top_addr", 1'b0);
      txn(GPIO_BASE + 4, 32'h7F, 4'hF, "btn_wr", 1'b0);
      txn(GPIO_BASE + 12, 32'hFF, 4'hF, "rsvd_wr", 1'b0);
      txn(GPIO_BASE + 12, 32'h0, 4'h0, "rsvd_rd", 1'b0);
      txn(GPIO_BASE, 32'h0000_FF00, 4'b0010, "led_wr_b1", 1'b0);
      txn(GPIO_BASE, 32'h0, 4'h0, "led_rd_b1", 1'b0);

      for (int i = 0; i < 120; i++) begin
         sel = int'($urandom_range(0, 99));
         d = $urandom;
         s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         if (sel < 40)      a = BRAM_BASE + 4 * $urandom_range(0, 15);
         else if (sel < 70) a = GPIO_BASE + 4 * $urandom_range(0, 3);
         else if (sel < 85) a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
         else               a = 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
         if ($urandom_range(0, 7) == 0) begin
            btn = 7'($urandom);
            repeat (3) @(negedge clk);
         end
         txn(a, d, s, "rand", 1'b0);
      end

      for (int i = 0; i < 260; i++)
         txn(32'h3000_0000 + 32'(4 * i), 32'h0, 4'h0, "sat_err", 1'b0);
      txn(GPIO_BASE + 8, 32'h0, 4'h0, "errcnt_sat", 1'b0);
      txn(GPIO_BASE + 8, 32'h0, 4'h1, "errcnt_clr2", 1'b0);

`ifdef MEM_BUS_DECODER_TIMEOUT_EN
      slv_en = 1'b0;
      txn(32'h0000_0010, 32'h0, 4'h0, "bram_timeout", 1'b1);
      slv_en = 1'b1;
      txn(GPIO_BASE + 8, 32'h0, 4'h0, "errcnt_after_to", 1'b0);
`endif

      txn(GPIO_BASE, 32'h3C, 4'h1, "led_set", 1'b0);
      slv_en = 1'b0;
      mem_addr = 32'h0000_0040;
      mem_wdata = 32'h0;
      mem_wstrb = 4'h0;
      mem_valid = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_rst_bram_valid", {31'h0, bram_valid}, 32'h1);
      #2;
      reset_n = 1'b0;
      mem_valid = 1'b0;
      #1;
      chk("mid_rst_bram_valid", {31'h0, bram_valid}, 32'h0);
      chk("mid_rst_mem_ready", {31'h0, mem_ready}, 32'h0);
      chk("mid_rst_led", {24'h0, led}, 32'h0);
      chk("mid_rst_mem_rdata", mem_rdata, 32'h0);
      ref_led = 8'h00;
      ref_err = 0;
      breq_q.delete();
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      slv_en = 1'b1;
      @(negedge clk);
      txn(32'h0000_0000, 32'h0, 4'h0, "post_rst_rd", 1'b0);
      txn(GPIO_BASE + 8, 32'h0, 4'h0, "post_rst_errcnt", 1'b0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
